// File: rtl/gfmult_arbiter_pkg.sv
// Shared GF(2^5) field constants for the decoder's GF blocks: requester count,
// symbol width and the field polynomial x^5+x^2+1.
package gfmult_arbiter_pkg;
  localparam int GFM_NUM_REQ = 4;
  localparam int GFM_GF_W    = 5;
  localparam logic [GFM_GF_W:0] GFM_POLY = 6'b100101;
endpackage

// File: rtl/gfmult_arbiter_if.sv
// Request/grant/result bundle between the requesters and the shared multiplier.
interface gfmult_arbiter_if;
  import gfmult_arbiter_pkg::*;

  logic [GFM_NUM_REQ-1:0]          req;
  logic [GFM_NUM_REQ*GFM_GF_W-1:0] opa;
  logic [GFM_NUM_REQ*GFM_GF_W-1:0] opb;
  logic                            hold;
  logic [GFM_NUM_REQ-1:0]          gnt;
  logic [GFM_NUM_REQ-1:0]          done;
  logic [GFM_GF_W-1:0]             result;

  modport master (output req, opa, opb, hold, input gnt, done, result);
  modport slave  (input req, opa, opb, hold, output gnt, done, result);
endinterface

// File: rtl/gfmult_arbiter_lcpmult.sv
// lcpmult: combinational GF(2^5) polynomial-basis multiplier
// (AND/XOR partial products followed by reduction modulo the field polynomial).
module lcpmult
  import gfmult_arbiter_pkg::*;
(
  input  logic [GFM_GF_W-1:0] i_a,
  input  logic [GFM_GF_W-1:0] i_b,
  output logic [GFM_GF_W-1:0] o_p
);
  logic [2*GFM_GF_W-2:0] w_full;

  always_comb begin
    w_full = '0;
    for (int i = 0; i < GFM_GF_W; i++) begin
      for (int j = 0; j < GFM_GF_W; j++) begin
        w_full[i+j] = w_full[i+j] ^ (i_a[i] & i_b[j]);
      end
    end
    // Fold high-order terms down from the top so each fold sees final bits.
    for (int k = 2*GFM_GF_W-2; k >= GFM_GF_W; k--) begin
      if (w_full[k]) begin
        w_full[k-GFM_GF_W +: GFM_GF_W+1] = w_full[k-GFM_GF_W +: GFM_GF_W+1] ^ GFM_POLY;
      end
    end
  end

  assign o_p = w_full[GFM_GF_W-1:0];
endmodule

// File: rtl/gfmult_arbiter.sv
// Round-robin arbiter sharing one GF(2^5) multiplier among four requesters.
// Define GFMULT_PIPE_EN to add a register stage after the multiplier (latency 2).
module gfmult_arbiter
  import gfmult_arbiter_pkg::*;
#(
  parameter int NUM_REQ = GFM_NUM_REQ,
  parameter int GF_W    = GFM_GF_W
)
(
  input  logic           clock,
  input  logic           reset,
  gfmult_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any;
  logic               w_grant_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [GF_W-1:0]    w_a;
  logic [GF_W-1:0]    w_b;
  logic [GF_W-1:0]    w_prod;
  logic [NUM_REQ-1:0] r_done;
  logic [GF_W-1:0]    r_result;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    w_any = 1'b0;
    w_idx = r_ptr;
    for (int off = NUM_REQ-1; off >= 0; off--) begin
      if (bus.req[r_ptr + PTR_W'(off)]) begin
        w_any = 1'b1;
        w_idx = r_ptr + PTR_W'(off);
      end
    end
  end

  assign w_grant_en = w_any & ~bus.hold & ~reset;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign w_gnt[gi] = w_grant_en && (w_idx == PTR_W'(gi));
    end
  endgenerate

  assign w_a = bus.opa[w_idx*GF_W +: GF_W];
  assign w_b = bus.opb[w_idx*GF_W +: GF_W];

  lcpmult u_mult (
    .i_a (w_a),
    .i_b (w_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant_en) begin
      r_ptr <= w_idx + PTR_W'(1);
    end
  end

`ifdef GFMULT_PIPE_EN
  logic [NUM_REQ-1:0] r_s1_oh;
  logic [GF_W-1:0]    r_s1_prod;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_oh   <= '0;
      r_s1_prod <= '0;
      r_done    <= '0;
      r_result  <= '0;
    end else if (!bus.hold) begin
      r_s1_oh   <= w_gnt;
      r_s1_prod <= w_grant_en ? w_prod : '0;
      r_done    <= r_s1_oh;
      r_result  <= r_s1_prod;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done   <= '0;
      r_result <= '0;
    end else if (!bus.hold) begin
      r_done   <= w_gnt;
      r_result <= w_grant_en ? w_prod : '0;
    end
  end
`endif

  assign bus.gnt    = w_gnt;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule

// File: doc/gfmult_arbiter.md
GFMULT_ARBITER -- requirements
Module: gfmult_arbiter

Interface
- REQ-001 Parameter NUM_REQ, default 4, meaning the number of requesters sharing the multiplier; only the value 4 is supported.
- REQ-002 Parameter GF_W, default 5, meaning the GF(2^5) symbol width; only the value 5 is supported.
- REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 Port req, input, 4 bits: request vector; bit i means requester i has an operand pair pending.
- REQ-006 Port opa, input, 20 bits: multiplicand; symbol i occupies bits [5i+4:5i], MSB at 5i+4.
- REQ-007 Port opb, input, 20 bits: multiplier, packed the same way as opa.
- REQ-008 Port hold, input, 1 bit: freezes the arbiter and pipeline; no grant is issued and no state changes.
- REQ-009 Port gnt, output, 4 bits: one-hot grant, combinational in the current cycle.
- REQ-010 Port done, output, 4 bits, registered: one-hot; bit i means result belongs to requester i.
- REQ-011 Port result, output, 5 bits, registered: GF(2^5) product, polynomial basis, x^5+x^2+1.

Function
- REQ-012 gnt SHALL be one-hot or zero, and SHALL be zero when hold=1 or reset=1.
- REQ-013 Arbitration SHALL be round-robin: search starts at pointer ptr (2 bits) and proceeds ptr, ptr+1, ... mod 4; the first requester with req=1 wins.
- REQ-014 On a grant to requester k with hold=0, ptr SHALL become (k+1) mod 4; with no grant, ptr SHALL be unchanged.
- REQ-015 The operands of the granted requester SHALL be captured in the grant cycle; the requester may change opa/opb or drop req from the next cycle.
- REQ-016 A requester keeping req=1 after a grant SHALL be treated as a new request.
- REQ-017 Latency, without GFMULT_PIPE_EN: done[k] and result SHALL be valid exactly 1 cycle after the gnt[k] cycle.
- REQ-018 Throughput SHALL be one grant per non-held cycle.
- REQ-019 done SHALL be a single-cycle pulse per grant.
- REQ-020 result SHALL be 0 whenever done=0.
- REQ-021 When hold=1, all registers (ptr, pipeline, done, result) SHALL keep their values.
- REQ-022 When hold=1, the done pulse present at hold assertion SHALL persist until hold drops.
- REQ-023 Operand value 0 SHALL yield result 0.
- REQ-024 Operand value 1 (5'b00001) SHALL be the identity.
- REQ-025 No carry or width growth: all arithmetic is GF, using XOR/AND only.

Reset
- REQ-026 When reset=1 at a clock edge: ptr=0, done=0, result=0, and all pipeline valid bits cleared.
- REQ-027 Reset SHALL take priority over hold.
- REQ-028 In-flight products SHALL be discarded on reset; no done pulse SHALL be issued for them.
- REQ-029 gnt SHALL be 0 while reset=1.

Configuration
- REQ-030 Macro GFMULT_PIPE_EN SHALL control pipelining: defined = a second register stage after the multiplier, giving latency 2 cycles gnt->done; undefined = latency 1.
- REQ-031 In both builds, throughput, arbitration order, hold and reset behaviour SHALL be identical; only done/result timing differs.

Structure
- REQ-032 A shared package/header SHALL hold NUM_REQ, GF_W and the field polynomial constant (6'b100101); the decoder's other GF blocks share these.
- REQ-033 The multiply SHALL be one instance of the existing GF(2^5) low-complexity parallel multiplier sub-module, lcpmult; no other sub-module.
- REQ-034 The arbiter, pointer, operand mux and pipeline registers SHALL be inline.

Verification
- REQ-035 Single request: req=0001, opa[4:0]=5'b00010, opb[4:0]=5'b10000 -> gnt=0001; next cycle done=0001, result=5'b00101 (alpha*alpha^4=alpha^5=x^2+1).
- REQ-036 All four requesting continuously from reset -> grants 0001,0010,0100,1000,0001...; each done follows its grant by the configured latency.
- REQ-037 ptr=2 with req=1011 -> gnt=1000; next arbitration with req=1011 -> gnt=0001.
- REQ-038 hold=1 for 3 cycles with req=1111 and a done pulse pending -> gnt=0, done/result frozen for 3 cycles, then resume in order.
- REQ-039 Reset asserted in the cycle after a grant -> no done pulse; ptr=0; the first post-reset grant goes to the lowest requesting index.
- REQ-040 Exhaustive check: all 1024 operand pairs issued via requester 3 -> every result matches the reference GF(2^5) product; 0 and 1 cases as in REQ-023/REQ-024.
